// File: rtl/led_frame_buffer.sv
// Double-buffered 8x8 red/green frame store for led_matrix_driver.
// Game logic draws into the hidden back bank; swaps land only on the scan frame boundary.
module led_frame_buffer #(
  parameter logic [7:0] CLEAR_RED    = 8'h00,
  parameter logic [7:0] CLEAR_GREEN  = 8'h00,
  parameter bit         SWAP_ON_WRAP = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [2:0] wr_col,
  input  logic [1:0] wr_color,
  input  logic       clear_req,
  input  logic       swap_req,
  input  logic [7:0] row_sink,
  output logic [7:0] red_array   [7:0],
  output logic [7:0] green_array [7:0],
  output logic       busy,
  output logic       swap_done,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;

  // Driver is lighting row 7; the next row it shows is row 0 of a new frame.
  localparam logic [7:0] ROW7_ACTIVE = 8'b0111_1111;

  state_t     state, state_next;
  logic [2:0] cnt;
  logic       front_sel;
  logic       back_sel;
  logic       do_write;
  logic       do_clear_row;
  logic       do_toggle;

  logic [7:0] red_bank   [0:1][0:7];
  logic [7:0] green_bank [0:1][0:7];

  assign back_sel  = ~front_sel;
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_comb begin
    state_next   = state;
    do_write     = 1'b0;
    do_clear_row = 1'b0;
    do_toggle    = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req)     state_next = CLEAR;
        else if (swap_req) state_next = WAIT_SWAP;
        else if (wr_en)    do_write   = 1'b1;
      end
      CLEAR: begin
        do_clear_row = 1'b1;
        if (cnt == 3'd7) state_next = IDLE;
      end
      WAIT_SWAP: begin
        if (!SWAP_ON_WRAP || (row_sink == ROW7_ACTIVE)) begin
          do_toggle  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      front_sel <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      state     <= state_next;
      swap_done <= do_toggle;
      if (do_toggle) front_sel <= ~front_sel;
      if (state == IDLE)  cnt <= 3'd0;
      else if (do_clear_row) cnt <= cnt + 3'd1;
    end
  end

  // Only the back bank is ever written, so the displayed frame is always complete.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) begin
          red_bank[b][r]   <= 8'h00;
          green_bank[b][r] <= 8'h00;
        end
      end
    end else if (do_clear_row) begin
      red_bank[back_sel][cnt]   <= CLEAR_RED;
      green_bank[back_sel][cnt] <= CLEAR_GREEN;
    end else if (do_write) begin
      red_bank[back_sel][wr_row][wr_col]   <= wr_color[0];
      green_bank[back_sel][wr_row][wr_col] <= wr_color[1];
    end
  end

  always_comb begin
    for (int r = 0; r < 8; r++) begin
      red_array[r]   = red_bank[front_sel][r];
      green_array[r] = green_bank[front_sel][r];
    end
  end

endmodule

// File: tb/tb_led_frame_buffer.sv
// Directed bench for led_frame_buffer: expected frames are queued at swap issue
// and checked by a monitor whenever swap_done pulses.
module tb_led_frame_buffer;

  logic       clock;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  logic [1:0] wr_color;
  logic       clear_req;
  logic       swap_req;
  logic [7:0] row_sink;
  logic [7:0] red_array   [7:0];
  logic [7:0] green_array [7:0];
  logic       busy;
  logic       swap_done;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;
  int swap_cnt = 0;
  logic [127:0] exp_q[$];

  bit       scan_en = 1'b0;
  int       row_idx = 0;

  led_frame_buffer #(
    .CLEAR_RED   (8'hFF),
    .CLEAR_GREEN (8'h00),
    .SWAP_ON_WRAP(1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_color   (wr_color),
    .clear_req  (clear_req),
    .swap_req   (swap_req),
    .row_sink   (row_sink),
    .red_array  (red_array),
    .green_array(green_array),
    .busy       (busy),
    .swap_done  (swap_done),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [127:0] mk(input logic [63:0] red, input logic [63:0] green);
    return {green, red};
  endfunction

  function automatic logic [127:0] cur_frame();
    logic [127:0] f;
    for (int r = 0; r < 8; r++) begin
      f[r*8 +: 8]      = red_array[r];
      f[64 + r*8 +: 8] = green_array[r];
    end
    return f;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (reset && swap_done) begin
      swap_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_swap_done", 128'd1, 128'd0);
      end else begin
        check("swap_frame", cur_frame(), exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clock);
    #1;
    if (scan_en) begin
      row_idx  = (row_idx + 1) % 8;
      row_sink = ~(8'h01 << row_idx);
    end
  endtask

  task automatic write_px(input logic [2:0] row, input logic [2:0] col, input logic [1:0] color);
    wr_en = 1'b1; wr_row = row; wr_col = col; wr_color = color;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic wait_swap(input string name, input int budget);
    int start;
    int n;
    start = swap_cnt;
    n = 0;
    while (swap_cnt == start && n < budget) begin
      cyc();
      n++;
    end
    if (swap_cnt == start) check({name, "_timeout"}, 128'd0, 128'd1);
  endtask

  task automatic swap_scanning(input string name, input logic [127:0] exp);
    exp_q.push_back(exp);
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
    check({name, "_busy"}, {127'd0, busy}, 128'd1);
    wait_swap(name, 40);
  endtask

  localparam logic [127:0] ZERO_F = 128'd0;
  localparam logic [127:0] FRAME_A = {64'h0100_0000_0000_0000, 64'h0000_0000_0020_0000};
  localparam logic [127:0] FRAME_B = {64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001};
  localparam logic [127:0] FRAME_C = {64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
  localparam logic [127:0] FRAME_D = {64'h0002_0000_0000_0000, 64'hFFFD_FFFF_FFFF_FFFF};

  initial begin
    int n;
    reset = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_color = '0;
    clear_req = 1'b0; swap_req = 1'b0; row_sink = 8'hFF;

    // reset state
    cyc(); cyc(); cyc();
    check("reset_frame", cur_frame(), ZERO_F);
    check("reset_busy", {127'd0, busy}, 128'd0);
    check("reset_swap_done", {127'd0, swap_done}, 128'd0);
    check("reset_state", {126'd0, fsm_state}, 128'd0);
    reset = 1'b1;
    row_idx = 0; row_sink = 8'hFE; scan_en = 1'b1;
    cyc();

    // two pixel writes, front untouched, then swap on frame boundary
    write_px(3'd2, 3'd5, 2'b01);
    write_px(3'd7, 3'd0, 2'b10);
    check("front_before_swap_a", cur_frame(), ZERO_F);
    swap_scanning("swap_a", FRAME_A);
    cyc();
    check("swap_done_one_cycle", {127'd0, swap_done}, 128'd0);

    // back-bank write does not disturb the front
    write_px(3'd0, 3'd0, 2'b11);
    cyc(); cyc();
    check("front_hold_b", cur_frame(), FRAME_A);
    swap_scanning("swap_b", FRAME_B);

    // clear: busy exactly 8 cycles, writes ignored meanwhile
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      wr_en = (n == 2); wr_row = 3'd3; wr_col = 3'd3; wr_color = 2'b10;
      cyc();
    end
    wr_en = 1'b0;
    check("clear_busy_cycles", 128'(n), 128'd8);
    check("front_hold_during_clear", cur_frame(), FRAME_B);
    swap_scanning("swap_c", FRAME_C);

    // clear > swap > write, all in one cycle
    clear_req = 1'b1; swap_req = 1'b1;
    wr_en = 1'b1; wr_row = 3'd4; wr_col = 3'd4; wr_color = 2'b10;
    cyc();
    clear_req = 1'b0; swap_req = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
    check("no_swap_after_priority", cur_frame(), FRAME_C);
    check("idle_after_priority", {127'd0, busy}, 128'd0);
    swap_scanning("swap_priority", FRAME_C);

    // swap requested while row 7 already showing waits a full scan
    write_px(3'd6, 3'd1, 2'b10);
    exp_q.push_back(FRAME_D);
    scan_en = 1'b0;
    @(negedge clock);
    row_sink = 8'b0111_1111; swap_req = 1'b1;
    @(posedge clock); #1;
    swap_req = 1'b0;
    row_idx = 0; row_sink = 8'hFE; scan_en = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      check($sformatf("row7_wait_front_%0d", k), cur_frame(), FRAME_C);
      check($sformatf("row7_wait_done_%0d", k), {127'd0, swap_done}, 128'd0);
    end
    cyc();
    check("row7_late_swap_done", {127'd0, swap_done}, 128'd1);
    cyc();

    // multi-zero row_sink never triggers the swap
    exp_q.push_back(FRAME_C);
    scan_en = 1'b0;
    row_sink = 8'b0011_1111;
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    check("illegal_row_no_swap", cur_frame(), FRAME_D);
    check("illegal_row_busy", {127'd0, busy}, 128'd1);
    row_sink = 8'b0111_1111;
    wait_swap("swap_after_illegal", 5);

    // reset mid-clear aborts immediately
    row_idx = 0; row_sink = 8'hFE; scan_en = 1'b1;
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    cyc(); cyc();
    check("midclear_busy", {127'd0, busy}, 128'd1);
    #2 reset = 1'b0;
    #1;
    check("midclear_reset_busy", {127'd0, busy}, 128'd0);
    check("midclear_reset_frame", cur_frame(), ZERO_F);
    check("midclear_reset_swap_done", {127'd0, swap_done}, 128'd0);
    @(negedge clock);
    reset = 1'b1;
    cyc(); cyc();
    check("after_reset_idle", {127'd0, busy}, 128'd0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_swaps: got %0d, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_frame_buffer.md
Name: led_frame_buffer

Overview:
Double-buffered 8x8 red/green frame store that produces the red_array/green_array inputs consumed by led_matrix_driver. Game logic draws pixels into the hidden back bank. Game logic can also clear the back bank. A swap request exchanges the banks only at the scan frame boundary, so the matrix never shows a half-drawn frame. The block sits between the flappy_bird game FSM and led_matrix_driver. It takes the driver's row_sink output to detect the boundary.

Parameters:
CLEAR_RED, 8'h00, row fill pattern written to every back-bank red row during a clear
CLEAR_GREEN, 8'h00, row fill pattern written to every back-bank green row during a clear
SWAP_ON_WRAP, 1, 1 = swap waits for frame boundary; 0 = swap on next clock

Ports:
clock  input  1  system clock, same clock as led_matrix_driver
reset  input  1  asynchronous, active-low reset
wr_en  input  1  pixel write strobe
wr_row  input  3  pixel row index 0..7
wr_col  input  3  pixel column (bit) index 0..7
wr_color  input  2  bit0 = red on, bit1 = green on (2'b11 = both/yellow)
clear_req  input  1  start clear of back bank
swap_req  input  1  request back/front exchange
row_sink  input  8  active-low row select from led_matrix_driver
red_array  output  8x[7:0]  front-bank red rows, unpacked [7:0] indexed by row
green_array  output  8x[7:0]  front-bank green rows
busy  output  1  high in CLEAR or WAIT_SWAP; requests ignored while high
swap_done  output  1  one-cycle pulse after a bank exchange

Behaviour:
- Storage: banks 0 and 1, each with 8 red rows and 8 green rows of 8 bits. Register front_sel picks the displayed bank; the back bank is !front_sel.
- Outputs red_array/green_array are a combinational mux of the front bank (zero latency).
- Reset (async, reset==0):
  - All bank bits = 0; front_sel = 0.
  - State = IDLE; busy = 0; swap_done = 0; clear row counter = 0.
  - Reset mid-clear or mid-wait aborts the operation; no pending state survives.
- Request priority in IDLE, same cycle: clear_req > swap_req > wr_en. Lower-priority requests in that cycle are dropped, not queued.
- Any request arriving while busy = 1 is ignored.
- Write (IDLE, wr_en=1): at the clock edge, back red[wr_row][wr_col] = wr_color[0] and back green[wr_row][wr_col] = wr_color[1]. The front bank is never written.
- State IDLE:
  - clear_req -> CLEAR with row counter 0.
  - else swap_req -> WAIT_SWAP.
  - else perform any write.
- State CLEAR:
  - Each cycle, back red[cnt] = CLEAR_RED, back green[cnt] = CLEAR_GREEN, then cnt++.
  - After cnt==7 is written -> IDLE.
  - Exactly 8 cycles with busy=1.
- State WAIT_SWAP:
  - With SWAP_ON_WRAP=1: on the edge where row_sink == 8'b01111111 (driver showing row 7), toggle front_sel -> IDLE. The driver's next row 0 then shows the new frame.
  - With SWAP_ON_WRAP=0: toggle on the first WAIT_SWAP edge.
  - If swap_req is sampled while row_sink == 8'b01111111 already holds, the swap still waits one full driver cycle. WAIT_SWAP is entered on that edge and needs a later row-7 sample.
  - Any other row_sink value, including illegal multi-zero patterns, does not trigger the swap.
- swap_done is registered: high for exactly the one cycle after front_sel toggles, else 0.
- busy is registered from state: high from the cycle after the accepting edge until return to IDLE.
- The back bank keeps the previous front contents after a swap. No auto-copy; a clear is required for a blank frame.

Test Plan:
1. Reset with reset=0 -> all red_array/green_array rows 8'h00, busy=0, swap_done=0; assert mid-CLEAR -> busy drops immediately.
2. Write (row 2, col 5, color 2'b01) and (row 7, col 0, color 2'b10), then swap_req with row_sink cycling -> at the row_sink=8'b01111111 edge, red_array[2]=8'h20 and green_array[7]=8'h01; swap_done pulses once.
3. With front showing content, write to the back bank -> red_array/green_array unchanged until the swap.
4. Params CLEAR_RED=8'hFF, CLEAR_GREEN=8'h00: clear_req -> busy high exactly 8 cycles; after swap, all red rows 8'hFF and green rows 8'h00. wr_en during busy has no effect.
5. clear_req, swap_req and wr_en all high in one IDLE cycle -> clear runs, the write is dropped, and no swap occurs (front_sel unchanged after 20 cycles).
6. swap_req issued while row_sink=8'b01111111 -> no toggle on that edge; toggle on the next row-7 edge, 8 driver cycles later.
